// File: rtl/cache_ctrl_pkg.sv
// Shared widths, address field helpers and FSM encoding for the direct-mapped data cache.
package cache_ctrl_pkg;
  localparam int ADDR_W         = 10;
  localparam int DATA_W         = 32;
  localparam int IDX_W          = 5;
  localparam int TAG_W          = 3;
  localparam int OFF_W          = 2;
  localparam int WORDS_PER_LINE = 1 << OFF_W;
  localparam int LINES          = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction
endpackage

// File: rtl/cache_ctrl_data_array.sv
// Valid/tag/data storage: async read port, sync word write, line-valid set.
// Only the valid bits are reset, so a partially refilled line is never seen as a hit.
module cache_ctrl_data_array
  import cache_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set_en,
  input  logic [IDX_W-1:0]  set_idx,
  input  logic [TAG_W-1:0]  set_tag
);
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS_PER_LINE];

  always_comb begin
    valid_d = valid_q;
    if (set_en) valid_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (set_en) tag_q[set_idx] <= set_tag;
    if (wr_en)  data_q[wr_idx][wr_off] <= wr_data;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_off];
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits are served combinationally; misses refill a 4-word line from data_mem.
module cache_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              stall,
  output logic              dm_re,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addrs,
  output logic [DATA_W-1:0] dm_wd,
  input  logic [DATA_W-1:0] dm_rd_2cache,
  input  logic [OFF_W-1:0]  word_offset,
  input  logic              ready
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wd_q, req_wd_d;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              stall_c;
  logic              arr_we, line_set;
  logic [IDX_W-1:0]  arr_idx;
  logic [OFF_W-1:0]  arr_off;
  logic [DATA_W-1:0] arr_wdata;

  cache_ctrl_data_array u_array (
    .clk      (clk),
    .rst      (reset),
    .rd_idx   (addr_idx(cpu_addr)),
    .rd_off   (addr_off(cpu_addr)),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (arr_we),
    .wr_idx   (arr_idx),
    .wr_off   (arr_off),
    .wr_data  (arr_wdata),
    .set_en   (line_set),
    .set_idx  (addr_idx(req_addr_q)),
    .set_tag  (addr_tag(req_addr_q))
  );

  assign hit = rd_valid && (rd_tag == addr_tag(cpu_addr));

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_wd_d   = req_wd_q;
    stall_c    = 1'b0;
    arr_we     = 1'b0;
    arr_idx    = addr_idx(cpu_addr);
    arr_off    = addr_off(cpu_addr);
    arr_wdata  = cpu_wd;
    line_set   = 1'b0;
    case (state_q)
      IDLE: begin
        // A store wins over a simultaneous load; the load is simply dropped.
        if (cpu_we) begin
          req_addr_d = cpu_addr;
          req_wd_d   = cpu_wd;
          arr_we     = hit;
          stall_c    = 1'b1;
          state_d    = WRITE;
        end else if (cpu_re && !hit) begin
          req_addr_d = cpu_addr;
          stall_c    = 1'b1;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        stall_c   = 1'b1;
        arr_we    = 1'b1;
        arr_idx   = addr_idx(req_addr_q);
        arr_off   = word_offset;
        arr_wdata = dm_rd_2cache;
        if (ready) begin
          line_set = 1'b1;
          state_d  = IDLE;
        end
      end
      WRITE: begin
        stall_c = !ready;
        if (ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      req_wd_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_wd_q   <= req_wd_d;
    end
  end

  assign dm_re    = (state_q == REFILL);
  assign dm_we    = (state_q == WRITE);
  assign dm_addrs = dm_re ? {req_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : req_addr_q;
  assign dm_wd    = req_wd_q;
  assign stall    = stall_c && !reset;
  assign cpu_rd   = reset ? '0 : rd_data;
endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed vector table, reset-mid-refill sequence,
// and random loads/stores checked against a line-presence model plus a shadow memory.
module tb_cache_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_re, cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        stall, dm_re, dm_we;
  logic [9:0]  dm_addrs;
  logic [31:0] dm_wd, dm_rd_2cache;
  logic [1:0]  word_offset;
  logic        ready;

  cache_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_re       (cpu_re),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wd       (cpu_wd),
    .cpu_rd       (cpu_rd),
    .stall        (stall),
    .dm_re        (dm_re),
    .dm_we        (dm_we),
    .dm_addrs     (dm_addrs),
    .dm_wd        (dm_wd),
    .dm_rd_2cache (dm_rd_2cache),
    .word_offset  (word_offset),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  // data_mem stand-in: beat counter runs while a request is up, clears otherwise.
  logic [31:0] mem [1024];
  logic [1:0]  cnt;
  bit          mem_init_done = 1'b0;

  assign word_offset  = cnt;
  assign ready        = (dm_re || dm_we) && (cnt == 2'd3);
  assign dm_rd_2cache = mem[{dm_addrs[9:2], cnt}];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 2'd0;
      if (!mem_init_done) begin
        for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
        mem_init_done <= 1'b1;
      end
    end else begin
      if (dm_re || dm_we) cnt <= cnt + 2'd1;
      else                cnt <= 2'd0;
      if (dm_we && ready) mem[dm_addrs] <= dm_wd;
    end
  end

  // Reference model: which tag each index holds, and what memory should contain.
  bit          ref_valid [32];
  logic [2:0]  ref_tag   [32];
  logic [31:0] ref_mem   [1024];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
  endtask

  // Issue one CPU request (called just after a posedge) and hold it until stall drops.
  task automatic op(input logic re, input logic we, input logic [9:0] addr, input logic [31:0] wd,
                    output int m_stall, output int m_re, output int m_we, output int m_both,
                    output logic [31:0] m_rd, output int e_stall, output int e_re,
                    output int e_we, output logic [31:0] e_rd, output bit tmo);
    bit done;
    bit hit;
    int idx;
    idx     = int'(addr[6:2]);
    hit     = ref_valid[idx] && (ref_tag[idx] == addr[9:7]);
    e_stall = we ? 4 : (hit ? 0 : 5);
    e_re    = (!we && !hit) ? 4 : 0;
    e_we    = we ? 4 : 0;
    e_rd    = ref_mem[addr];
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wd = wd;
    m_stall = 0; m_re = 0; m_we = 0; m_both = 0; m_rd = '0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (dm_re) m_re++;
      if (dm_we) m_we++;
      if (dm_re && dm_we) m_both++;
      if (stall) m_stall++;
      else begin
        done = 1'b1;
        m_rd = cpu_rd;
      end
      @(posedge clk); #1;
    end
    tmo = !done;
    cpu_re = 1'b0; cpu_we = 1'b0;
    if (we) ref_mem[addr] = wd;
    else if (!hit) begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = addr[9:7];
    end
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
    int          stl;
    int          nre;
    int          nwe;
    logic [31:0] rd;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int ms, mre, mwe, mb, es, ere, ewe;
    logic [31:0] mrd, erd;
    bit tmo;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hA5A5_0000 | 32'(i);
    model_reset();

    tbl.push_back('{1'b1, 1'b0, 10'h004, 32'h0,         5, 4, 0, 32'hA5A5_0004, "cold_rd_004"});
    tbl.push_back('{1'b1, 1'b0, 10'h005, 32'h0,         0, 0, 0, 32'hA5A5_0005, "hit_rd_005"});
    tbl.push_back('{1'b1, 1'b0, 10'h006, 32'h0,         0, 0, 0, 32'hA5A5_0006, "hit_rd_006"});
    tbl.push_back('{1'b1, 1'b0, 10'h007, 32'h0,         0, 0, 0, 32'hA5A5_0007, "hit_rd_007"});
    tbl.push_back('{1'b0, 1'b1, 10'h005, 32'hDEAD_BEEF, 4, 0, 4, 32'h0,         "st_hit_005"});
    tbl.push_back('{1'b1, 1'b0, 10'h005, 32'h0,         0, 0, 0, 32'hDEAD_BEEF, "reload_005"});
    tbl.push_back('{1'b0, 1'b1, 10'h100, 32'h0000_1234, 4, 0, 4, 32'h0,         "st_miss_100"});
    tbl.push_back('{1'b1, 1'b0, 10'h100, 32'h0,         5, 4, 0, 32'h0000_1234, "rd_after_st_miss"});
    tbl.push_back('{1'b1, 1'b0, 10'h008, 32'h0,         5, 4, 0, 32'hA5A5_0008, "conf_rd_008"});
    tbl.push_back('{1'b1, 1'b0, 10'h088, 32'h0,         5, 4, 0, 32'hA5A5_0088, "conf_rd_088"});
    tbl.push_back('{1'b1, 1'b0, 10'h008, 32'h0,         5, 4, 0, 32'hA5A5_0008, "conf_rerd_008"});
    tbl.push_back('{1'b1, 1'b1, 10'h00C, 32'h0C0C_0C0C, 4, 0, 4, 32'h0,         "re_we_00C"});
    tbl.push_back('{1'b1, 1'b0, 10'h00C, 32'h0,         5, 4, 0, 32'h0C0C_0C0C, "rd_after_re_we"});

    reset = 1'b1; cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h004; cpu_wd = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dm_re", 32'(dm_re), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_cpu_rd", cpu_rd, 32'd0);
    cpu_re = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      op(tbl[k].re, tbl[k].we, tbl[k].addr, tbl[k].wd, ms, mre, mwe, mb, mrd, es, ere, ewe, erd, tmo);
      chk({tbl[k].nm, "_timeout"}, 32'(tmo), 32'd0);
      chk({tbl[k].nm, "_stall"}, 32'(ms), 32'(tbl[k].stl));
      chk({tbl[k].nm, "_dm_re"}, 32'(mre), 32'(tbl[k].nre));
      chk({tbl[k].nm, "_dm_we"}, 32'(mwe), 32'(tbl[k].nwe));
      chk({tbl[k].nm, "_both"}, 32'(mb), 32'd0);
      if (tbl[k].we) chk({tbl[k].nm, "_mem"}, mem[tbl[k].addr], tbl[k].wd);
      else           chk({tbl[k].nm, "_rd"}, mrd, tbl[k].rd);
    end

    // Reset during the beat-2 cycle of a refill.
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h014;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_rst_pre_dm_re", 32'(dm_re), 32'd1);
    chk("mid_rst_pre_beat", 32'(word_offset), 32'd2);
    reset = 1'b1; cpu_re = 1'b0;
    #1;
    chk("mid_rst_dm_re", 32'(dm_re), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("mid_rst_dm_re_next", 32'(dm_re), 32'd0);
    chk("mid_rst_cnt", 32'(word_offset), 32'd0);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    op(1'b1, 1'b0, 10'h014, 32'h0, ms, mre, mwe, mb, mrd, es, ere, ewe, erd, tmo);
    chk("post_rst_timeout", 32'(tmo), 32'd0);
    chk("post_rst_stall", 32'(ms), 32'd5);
    chk("post_rst_dm_re", 32'(mre), 32'd4);
    chk("post_rst_rd", mrd, 32'hA5A5_0014);
    op(1'b1, 1'b0, 10'h005, 32'h0, ms, mre, mwe, mb, mrd, es, ere, ewe, erd, tmo);
    chk("post_rst_old_line_stall", 32'(ms), 32'd5);
    chk("post_rst_old_line_rd", mrd, 32'hDEAD_BEEF);

    // Random loads/stores over a small footprint so hits, conflicts and store-hits all occur.
    for (int n = 0; n < 200; n++) begin
      int kind;
      logic re, we;
      logic [9:0] a;
      logic [31:0] d;
      kind = int'($urandom_range(0, 3));
      we   = (kind == 0) || (kind == 3);
      re   = (kind != 0);
      a    = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      d    = $urandom;
      op(re, we, a, d, ms, mre, mwe, mb, mrd, es, ere, ewe, erd, tmo);
      chk("rnd_timeout", 32'(tmo), 32'd0);
      chk("rnd_stall", 32'(ms), 32'(es));
      chk("rnd_dm_re", 32'(mre), 32'(ere));
      chk("rnd_dm_we", 32'(mwe), 32'(ewe));
      chk("rnd_both", 32'(mb), 32'd0);
      if (we) chk("rnd_mem", mem[a], d);
      else    chk("rnd_rd", mrd, erd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
